// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage: PC sequencing, credit-limited imem requests,
// in-order response buffering and redirect flush towards decode.
module rv32i_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic [6:0]  if_opcode,
   output logic        misalign_err
);
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t state, state_next;

   logic [31:0]   pc;
   logic [CW-1:0] outstanding, outstanding_next, discard, occupancy;
   logic [CW:0]   credit_used;
   logic [PW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
   logic [31:0]   tag_pc  [BUF_DEPTH];
   logic [31:0]   buf_pc  [BUF_DEPTH];
   logic [31:0]   buf_ins [BUF_DEPTH];
   logic          req_fire, redir, redir_ok, redir_bad, rsp_keep, pop;

   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = RUN;
         RUN:     if (redir_bad) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = BOOT;
      endcase
   end

   // Credits cover both in-flight requests and buffered entries, so every
   // response always finds a free buffer slot.
   always_comb begin
      credit_used      = {1'b0, outstanding} + {1'b0, occupancy};
      imem_req_valid   = (state == RUN) && (credit_used < DEPTH_C);
      imem_req_addr    = pc;
      req_fire         = imem_req_valid && imem_req_ready;
      redir            = (state == RUN) && redirect_valid;
      redir_ok         = redir && (redirect_pc[1:0] == 2'b00);
      redir_bad        = redir && !redir_ok;
      rsp_keep         = imem_rsp_valid && (state == RUN) && !redir && (discard == '0);
      if_valid         = (occupancy != '0);
      pop              = if_valid && if_ready && !redir;
      outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if_pc            = if_valid ? buf_pc[buf_rd]  : '0;
      if_instruction   = if_valid ? buf_ins[buf_rd] : '0;
      if_opcode        = if_instruction[6:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         outstanding  <= '0;
         discard      <= '0;
         occupancy    <= '0;
         tag_wr       <= '0;
         tag_rd       <= '0;
         buf_wr       <= '0;
         buf_rd       <= '0;
         misalign_err <= 1'b0;
      end else begin
         state       <= state_next;
         outstanding <= outstanding_next;
         if (redir_ok)
            pc <= redirect_pc;
         else if (req_fire)
            pc <= pc + 32'd4;
         if (req_fire)
            tag_wr <= tag_wr + PW'(1);
         if (imem_rsp_valid)
            tag_rd <= tag_rd + PW'(1);
         // Everything still in flight after this edge belongs to the old path.
         if (redir)
            discard <= outstanding_next;
         else if (imem_rsp_valid && (discard != '0))
            discard <= discard - CW'(1);
         if (redir) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            occupancy <= '0;
         end else begin
            if (rsp_keep)
               buf_wr <= buf_wr + PW'(1);
            if (pop)
               buf_rd <= buf_rd + PW'(1);
            occupancy <= occupancy + CW'(rsp_keep) - CW'(pop);
         end
         if (redir_bad)
            misalign_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire)
         tag_pc[tag_wr] <= pc;
      if (rsp_keep) begin
         buf_pc[buf_wr]  <= tag_pc[tag_rd];
         buf_ins[buf_wr] <= imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Randomized bench for rv32i_fetch_stage: in-order memory model with variable
// latency and a PC-stream reference for what decode must observe.
module tb_rv32i_fetch_stage;
   localparam int          BUF_DEPTH = 2;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic        clk, rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_pc, if_instruction;
   logic [6:0]  if_opcode;
   logic        misalign_err;

   rv32i_fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
      .if_instruction(if_instruction), .if_opcode(if_opcode),
      .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, since_rst = 0, last_due = 0;
   int lat_lo = 1, lat_hi = 1, rdy_pct = 100, ifr_pct = 100;
   int accepts = 0, first_vld = -1, pop_total = 0;
   logic        halted = 1'b0, prev_redir = 1'b0, prev_hold = 1'b0;
   logic [31:0] exp_pc, exp_req, prev_pc, prev_ins;
   logic [6:0]  first_opc;
   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] dq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'h0000_0013;
   endfunction

   function automatic logic [31:0] dq_at(input int i);
      return (i < dq.size()) ? dq[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic do_reset(input int n);
      rst = 1'b1;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      if_ready = 1'b0;
      repeat (n) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      chk("rst_reqv", imem_req_valid, 0);
      chk("rst_ifv", if_valid, 0);
      chk("rst_err", misalign_err, 0);
      chk("rst_addr", imem_req_addr, RESET_PC);
      chk("rst_ifpc", if_pc, 0);
      chk("rst_ins", if_instruction, 0);
      chk("rst_opc", {25'b0, if_opcode}, 0);
      rst = 1'b0;
      q_addr.delete();
      q_due.delete();
      dq.delete();
      last_due = cyc;
      exp_pc = RESET_PC;
      exp_req = RESET_PC;
      since_rst = 0;
      halted = 1'b0;
      prev_redir = 1'b0;
      prev_hold = 1'b0;
      accepts = 0;
      first_vld = -1;
   endtask

   // One clock: drive inputs at the negedge, check outputs, advance the model.
   task automatic cycle(input logic rd, input logic [31:0] tgt);
      logic        fire, eff;
      logic [31:0] w;
      int          lat, due;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      if_ready = ($urandom_range(99) < ifr_pct);
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = mem_word(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = $urandom;
      end
      redirect_valid = rd;
      redirect_pc = tgt;
      #1;
      if (prev_redir) chk("flush", if_valid, 0);
      if (prev_hold) begin
         chk("hold_vld", if_valid, 1);
         chk("hold_pc", if_pc, prev_pc);
         chk("hold_ins", if_instruction, prev_ins);
      end
      if (halted) begin
         chk("halt_err", misalign_err, 1);
         chk("halt_reqv", imem_req_valid, 0);
         chk("halt_ifv", if_valid, 0);
      end else begin
         chk("err_clr", misalign_err, 0);
         if (since_rst == 0) chk("boot_reqv", imem_req_valid, 0);
      end
      fire = imem_req_valid && imem_req_ready;
      if (fire) begin
         chk("req_addr", imem_req_addr, exp_req);
         exp_req = exp_req + 32'd4;
         lat = int'($urandom_range(lat_hi, lat_lo));
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         q_addr.push_back(imem_req_addr);
         q_due.push_back(due);
         accepts++;
         chk("credit", (q_due.size() <= BUF_DEPTH), 1);
      end
      if (if_valid) begin
         w = mem_word(exp_pc);
         chk("if_pc", if_pc, exp_pc);
         chk("if_ins", if_instruction, w);
         chk("if_opc", {25'b0, if_opcode}, {25'b0, w[6:0]});
         if (first_vld < 0) begin
            first_vld = since_rst;
            first_opc = if_opcode;
         end
         if (if_ready) begin
            dq.push_back(if_pc);
            pop_total++;
            exp_pc = exp_pc + 32'd4;
         end
      end
      eff = rd && !halted && (since_rst >= 1);
      if (eff) begin
         if (tgt[1:0] == 2'b00) begin
            exp_pc = tgt;
            exp_req = tgt;
         end else begin
            halted = 1'b1;
         end
      end
      prev_redir = eff;
      prev_hold = if_valid && !if_ready && !eff;
      prev_pc = if_pc;
      prev_ins = if_instruction;
      @(posedge clk);
      cyc++;
      since_rst++;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

   initial begin
      logic hit;
      int   n;
      rst = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      if_ready = 1'b0;
      @(negedge clk);

      // Streaming, latency 1; a redirect during BOOT must be ignored.
      do_reset(2);
      lat_lo = 1; lat_hi = 1; rdy_pct = 100; ifr_pct = 100;
      cycle(1'b1, 32'h0000_0200);
      repeat (12) cycle(1'b0, '0);
      chk("first_lat", first_vld, 3);
      chk("first_opc", {25'b0, first_opc}, 32'h13);
      chk("stream_cnt", (dq.size() >= 4), 1);

      // Backpressure: decode stalls, requests stop at the credit limit.
      do_reset(1);
      ifr_pct = 0;
      repeat (10) cycle(1'b0, '0);
      chk("bp_accepts", accepts, BUF_DEPTH);
      chk("bp_reqv", imem_req_valid, 0);
      chk("bp_ifv", if_valid, 1);
      ifr_pct = 100;
      repeat (10) cycle(1'b0, '0);
      chk("bp_drain", (dq.size() >= 4), 1);

      // Redirect with two requests in flight, latency 3.
      do_reset(1);
      lat_lo = 3; lat_hi = 3;
      n = 0;
      while (q_due.size() < 2 && n < 20) begin
         cycle(1'b0, '0);
         n++;
      end
      chk("inflight2", q_due.size(), 2);
      cycle(1'b1, 32'h0000_0100);
      dq.delete();
      repeat (15) cycle(1'b0, '0);
      chk("rd_first", dq_at(0), 32'h0000_0100);
      chk("rd_second", dq_at(1), 32'h0000_0104);

      // Redirect coinciding with a response and a request accept.
      do_reset(1);
      lat_lo = 1; lat_hi = 1;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 20) begin
         if (q_due.size() > 0 && q_due[0] == cyc && imem_req_valid) hit = 1'b1;
         else cycle(1'b0, '0);
         n++;
      end
      chk("sim_hit", hit, 1);
      dq.delete();
      cycle(1'b1, 32'h0000_0300);
      repeat (12) cycle(1'b0, '0);
      chk("sim_first", dq_at(0), 32'h0000_0300);
      chk("sim_second", dq_at(1), 32'h0000_0304);

      // Misaligned redirect halts until reset; redirects in HALT are ignored.
      do_reset(1);
      lat_lo = 2; lat_hi = 2;
      repeat (6) cycle(1'b0, '0);
      cycle(1'b1, 32'h0000_0102);
      repeat (4) cycle(1'b0, '0);
      cycle(1'b1, 32'h0000_0200);
      repeat (4) cycle(1'b0, '0);
      chk("mis_err", misalign_err, 1);
      do_reset(1);
      repeat (8) cycle(1'b0, '0);
      chk("mis_restart", dq_at(0), RESET_PC);
      chk("mis_err_clr", misalign_err, 0);

      // PC wrap at the top of the address space.
      do_reset(1);
      lat_lo = 1; lat_hi = 1;
      repeat (4) cycle(1'b0, '0);
      cycle(1'b1, 32'hFFFF_FFFC);
      dq.delete();
      repeat (12) cycle(1'b0, '0);
      chk("wrap0", dq_at(0), 32'hFFFF_FFFC);
      chk("wrap1", dq_at(1), 32'h0000_0000);

      // Random traffic with a mid-run reset.
      do_reset(1);
      lat_lo = 1; lat_hi = 4; rdy_pct = 70; ifr_pct = 60;
      pop_total = 0;
      for (int i = 0; i < 3000; i++) begin
         logic        rd;
         logic [31:0] tgt;
         rd = ($urandom_range(99) < 4);
         tgt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(9) == 0) tgt = 32'hFFFF_FFF0;
         if (i == 1500) do_reset(2);
         else cycle(rd, tgt);
      end
      chk("rand_progress", (pop_total > 100), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv32i_fetch_stage.md
Name: rv32i_fetch_stage

Overview:
- Instruction-fetch stage of the RV32I core; sits directly upstream of decode and the immediate generator.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions and presents {pc, instruction, opcode} to decode over a valid/ready handshake.
- Accepts branch/jump redirects, flushing stale in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2, output buffer entries and maximum outstanding requests (power of 2, >=2).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; responses in request order, latency >=1 cycle, no backpressure
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new PC
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_pc  out  32  PC of presented instruction
- if_instruction  out  32  presented instruction word
- if_opcode  out  7  if_instruction[6:0]
- misalign_err  out  1  sticky: misaligned redirect received

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, buffer empty, outstanding=0, discard=0, state=BOOT. Outputs after reset: imem_req_valid=0, if_valid=0, misalign_err=0, imem_req_addr=RESET_PC, if_pc=0, if_instruction=0, if_opcode=0.
- Reset mid-operation: everything returns to the reset values. Responses to pre-reset requests are unspecified; the memory must also be reset.
- FSM states: BOOT, RUN, HALT.
  - BOOT->RUN after one cycle.
  - RUN->HALT on a misaligned redirect (redirect_pc[1:0]!=0).
  - HALT exits only on rst.
- Request issue (RUN only): imem_req_valid=1 when outstanding+occupancy < BUF_DEPTH. This credit rule guarantees every response has a buffer slot.
  - imem_req_addr=pc.
  - On accept (valid&ready): pc<=pc+4 (wraps mod 2^32, 0xFFFF_FFFC->0x0000_0000) and outstanding++.
  - The request's PC is pushed to a PC tag FIFO of depth BUF_DEPTH.
- Response: each rsp_valid decrements outstanding.
  - If discard>0: the response is dropped, discard--, and its tag popped.
  - Otherwise {tag pc, rsp_data} is pushed to the output buffer.
- Output: if_valid = buffer non-empty; fields come from the head entry. Pop on if_valid&if_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - Fields hold stable while if_valid&!if_ready.
- Redirect (RUN, aligned): takes effect at the clock edge.
  - pc<=redirect_pc; output buffer flushed (if_valid=0 next cycle).
  - discard <= outstanding_next, counting any request accepted that same cycle and excluding any response arriving that same cycle. A response arriving in the redirect cycle is dropped and not buffered.
  - Requests resume the next cycle from redirect_pc.
- Redirect priority: over request-accept PC increment, response push and if pop. A decode pop in the redirect cycle is still considered consumed.
- Misaligned redirect: misalign_err<=1 (sticky), buffer flushed, state HALT.
  - In HALT: imem_req_valid=0, if_valid=0; responses are drained and dropped.
- redirect_valid is ignored in BOOT and HALT.
- Latency: an accepted request whose response arrives N cycles later appears on if_valid at cycle N+1, via registered buffer write.

Test Plan:
- Reset, streaming: rst 2 cycles, mem latency 1, if_ready=1. Expect imem_req_addr sequence 0,4,8,C; if_pc 0,4,8 with matching instructions; if_opcode 0x13 for 0x00000013.
- Backpressure: if_ready=0 for 5 cycles after the first instruction. Expect at most 2 accepted requests outstanding+buffered, imem_req_valid=0 thereafter, if fields stable; on release, in-order delivery with no loss or duplication.
- Redirect with in-flight: latency 3, redirect_pc=0x100 while 2 requests are outstanding. Expect both stale responses dropped and the next if_pc=0x100, then 0x104.
- Simultaneous redirect + response + request accept in one cycle. Expect that response dropped, the accepted request's response dropped, and the first delivered if_pc=redirect_pc.
- Misaligned redirect to 0x102. Expect misalign_err=1 next cycle and staying 1, imem_req_valid=0 and if_valid=0 until rst, then restart at RESET_PC with err=0.
- Wrap: redirect to 0xFFFF_FFFC. Expect requests at 0xFFFF_FFFC then 0x0000_0000; if_pc matches.
